bwt_key_streamer: RTL and testbench

//  Builds BWT prefix-doubling sort keys {idx, rank[idx], rank[idx+offset]} for every suffix.

---
 rtl/bwt_key_streamer.sv | 128 ++++++++++++
 tb/tb_bwt_key_streamer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bwt_key_streamer.sv
// Streams BWT prefix-doubling sort keys {idx, rank[idx], rank[idx+offset]} over valid/ready,
// LANES keys per beat, from a snapshot of the rank buffer taken at start.
//
//   state | meaning
//   IDLE  | waiting for start; snapshot registers hold the previous pass
//   LOAD  | reduce captured offset mod N (cyclic mode only; pad mode passes straight through)
//   EMIT  | key_valid high, cnt advances by LANES on each accepted beat
//   DONE  | one-cycle done pulse, then back to IDLE
module bwt_key_streamer #(
  parameter int STRING_LEN = 8,
  parameter int RANK_W     = 8,
  parameter int IDX_W      = 8,
  parameter int LANES      = 1,
  parameter logic [RANK_W-1:0] PAD_VALUE = '0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  cyclic,
  input  logic [IDX_W-1:0]                      offset,
  input  logic [STRING_LEN*RANK_W-1:0]          buckets,
  output logic                                  key_valid,
  input  logic                                  key_ready,
  output logic [LANES*(IDX_W+2*RANK_W)-1:0]     key_data,
  output logic                                  busy,
  output logic                                  done
);

  localparam int KEY_W = IDX_W + 2*RANK_W;
  localparam int SW    = IDX_W + 1;
  localparam logic [SW-1:0] N_W     = SW'(STRING_LEN);
  localparam logic [SW-1:0] LANES_W = SW'(LANES);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT, S_DONE} state_t;

  state_t                         state_q, state_d;
  logic [STRING_LEN*RANK_W-1:0]   snap_q, snap_d;
  logic [IDX_W-1:0]               off_q, off_d;
  logic                           cyc_q, cyc_d;
  logic [SW-1:0]                  cnt_q, cnt_d;
  logic [LANES*KEY_W-1:0]         keys;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      off_q   <= '0;
      cyc_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      off_q   <= off_d;
      cyc_q   <= cyc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    off_d     = off_q;
    cyc_d     = cyc_q;
    cnt_d     = cnt_q;
    key_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          snap_d  = buckets;
          off_d   = offset;
          cyc_d   = cyclic;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // One subtraction per cycle keeps the reduction free of a divider.
        if (cyc_q && ({1'b0, off_q} >= N_W)) begin
          off_d = IDX_W'({1'b0, off_q} - N_W);
        end else begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        key_valid = 1'b1;
        if (key_ready) begin
          cnt_d = cnt_q + LANES_W;
          if (cnt_q + LANES_W == N_W) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    logic [SW-1:0]     idx, sum, sidx;
    logic [RANK_W-1:0] first, second;
    keys   = '0;
    idx    = '0;
    sum    = '0;
    sidx   = '0;
    first  = '0;
    second = '0;
    for (int l = 0; l < LANES; l++) begin
      idx    = cnt_q + SW'(l);
      sum    = idx + {1'b0, off_q};
      // off_q < N once cyclic LOAD finishes, so a single conditional wrap suffices.
      sidx   = (cyc_q && (sum >= N_W)) ? (sum - N_W) : sum;
      first  = '0;
      second = PAD_VALUE;
      for (int j = 0; j < STRING_LEN; j++) begin
        if (idx == SW'(j)) first = snap_q[j*RANK_W +: RANK_W];
        if ((cyc_q || (sum < N_W)) && (sidx == SW'(j))) second = snap_q[j*RANK_W +: RANK_W];
      end
      keys[l*KEY_W +: KEY_W] = {idx[IDX_W-1:0], first, second};
    end
  end

  assign key_data = (state_q == S_EMIT) ? keys : '0;

endmodule

// File: tb/tb_bwt_key_streamer.sv
// Bench for bwt_key_streamer: table of passes on a LANES=1 instance with a key scoreboard,
// plus a hand-written LANES=2 pass.
module tb_bwt_key_streamer;
  localparam int N  = 8;
  localparam int RW = 8;
  localparam int IW = 8;
  localparam int KW = IW + 2*RW;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_a, start_b;
  logic            cyclic;
  logic [IW-1:0]   offset;
  logic [N*RW-1:0] buckets;
  logic            key_ready_a, key_ready_b;
  logic            key_valid_a, key_valid_b;
  logic [KW-1:0]   key_data_a;
  logic [2*KW-1:0] key_data_b;
  logic            busy_a, busy_b, done_a, done_b;

  bwt_key_streamer #(.STRING_LEN(N), .RANK_W(RW), .IDX_W(IW), .LANES(1), .PAD_VALUE(8'h00)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .cyclic(cyclic), .offset(offset), .buckets(buckets),
    .key_valid(key_valid_a), .key_ready(key_ready_a), .key_data(key_data_a),
    .busy(busy_a), .done(done_a));

  bwt_key_streamer #(.STRING_LEN(N), .RANK_W(RW), .IDX_W(IW), .LANES(2), .PAD_VALUE(8'h00)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .cyclic(cyclic), .offset(offset), .buckets(buckets),
    .key_valid(key_valid_b), .key_ready(key_ready_b), .key_data(key_data_b),
    .busy(busy_b), .done(done_b));

  always #5 clk = ~clk;

  typedef struct {
    logic            cyc;
    logic [IW-1:0]   off;
    logic [N*RW-1:0] bk;
    int              stall_at;
    int              stall_len;
    bit              rnd;
    int              lat;
    int              abort_at;
    bit              poke;
  } vec_t;

  int            vecs = 0;
  int            errs = 0;
  logic [KW-1:0] sb[$];
  logic [KW-1:0] got[N];
  logic [KW-1:0] got_t1[N];
  logic [KW-1:0] got_t3[N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [KW-1:0] mk(input logic [N*RW-1:0] bk, input logic cyc,
                                       input int off, input int idx);
    logic [RW-1:0] r0, r1;
    logic [IW-1:0] iv;
    int            s;
    iv = IW'(idx);
    r0 = bk[idx*RW +: RW];
    if (cyc) begin
      s  = (idx + (off % N)) % N;
      r1 = bk[s*RW +: RW];
    end else if (idx + off < N) begin
      r1 = bk[(idx+off)*RW +: RW];
    end else begin
      r1 = 8'h00;
    end
    return {iv, r0, r1};
  endfunction

  task automatic run_a(input vec_t v);
    int   t, beats, cyc_cnt, stall_cnt;
    bit   prev_stall, rdy;
    logic [KW-1:0] prev_data, exp;
    buckets = v.bk;
    cyclic  = v.cyc;
    offset  = v.off;
    start_a = 1'b1;
    key_ready_a = 1'b1;
    for (int i = 0; i < N; i++) sb.push_back(mk(v.bk, v.cyc, int'(v.off), i));
    tick();
    start_a = 1'b0;
    // Scramble inputs: the pass must run from the snapshot.
    buckets = ~v.bk;
    cyclic  = ~v.cyc;
    offset  = ~v.off;
    t = 0;
    while (!key_valid_a && t < 60) begin
      tick();
      t++;
    end
    check("first_valid_latency", 64'(t), 64'(v.lat));
    beats = 0; cyc_cnt = 0; stall_cnt = 0; prev_stall = 0; prev_data = '0;
    while (beats < N && cyc_cnt < 200) begin
      if (beats == v.abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid", 64'(key_valid_a), 64'd0);
        check("abort_busy", 64'(busy_a), 64'd0);
        check("abort_done", 64'(done_a), 64'd0);
        check("abort_data", 64'(key_data_a), 64'd0);
        for (int k = 0; k < 3; k++) begin
          tick();
          check("abort_no_done", 64'({done_a, busy_a, key_valid_a}), 64'd0);
        end
        sb.delete();
        return;
      end
      rdy = 1'b1;
      if (beats == v.stall_at && stall_cnt < v.stall_len) begin
        rdy = 1'b0;
        stall_cnt++;
      end else if (v.rnd) begin
        rdy = 1'($urandom_range(0, 1));
      end
      key_ready_a = rdy;
      start_a = v.poke && (beats == 2);
      check("valid_held", 64'(key_valid_a), 64'd1);
      if (prev_stall) check("stall_stable", 64'(key_data_a), 64'(prev_data));
      if (key_valid_a && rdy) begin
        exp = (sb.size() > 0) ? sb.pop_front() : '1;
        check($sformatf("key%0d", beats), 64'(key_data_a), 64'(exp));
        got[beats] = key_data_a;
        beats++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = 1'b1;
        prev_data  = key_data_a;
      end
      tick();
      cyc_cnt++;
    end
    start_a = 1'b0;
    check("beats_delivered", 64'(beats), 64'(N));
    if (v.stall_at < 0 && !v.rnd) check("no_bubbles", 64'(cyc_cnt), 64'(N));
    check("done_pulse", 64'({done_a, key_valid_a, busy_a}), 64'b101);
    check("sb_empty", 64'(sb.size()), 64'd0);
    start_a = v.poke;
    tick();
    start_a = 1'b0;
    check("after_done", 64'({done_a, busy_a}), 64'd0);
    tick();
    check("idle_after_done", 64'({busy_a, key_valid_a}), 64'd0);
    sb.delete();
  endtask

  localparam logic [N*RW-1:0] BK_T = {8'd6, 8'd2, 8'd9, 8'd5, 8'd1, 8'd4, 8'd1, 8'd3};

  vec_t tbl[13];

  initial begin
    int t;
    logic [2*KW-1:0] expb;
    tbl[0]  = '{1'b0, 8'd2,   BK_T, -1, 0, 1'b0, 1,  -1, 1'b0};
    tbl[1]  = '{1'b1, 8'd2,   BK_T, -1, 0, 1'b0, 1,  -1, 1'b0};
    tbl[2]  = '{1'b1, 8'd19,  BK_T, -1, 0, 1'b0, 3,  -1, 1'b0};
    tbl[3]  = '{1'b1, 8'd3,   BK_T, -1, 0, 1'b0, 1,  -1, 1'b0};
    tbl[4]  = '{1'b0, 8'd2,   BK_T,  3, 5, 1'b1, 1,  -1, 1'b0};
    tbl[5]  = '{1'b0, 8'd12,  {$urandom, $urandom}, -1, 0, 1'b0, 1,  -1, 1'b0};
    tbl[6]  = '{1'b1, 8'd0,   {$urandom, $urandom}, -1, 0, 1'b0, 1,  -1, 1'b0};
    tbl[7]  = '{1'b0, 8'd0,   {$urandom, $urandom}, -1, 0, 1'b1, 1,  -1, 1'b0};
    tbl[8]  = '{1'b1, 8'd8,   {$urandom, $urandom}, -1, 0, 1'b0, 2,  -1, 1'b0};
    tbl[9]  = '{1'b1, 8'd255, {$urandom, $urandom}, -1, 0, 1'b1, 32, -1, 1'b0};
    tbl[10] = '{1'b0, 8'd1,   BK_T, -1, 0, 1'b0, 1,   3, 1'b0};
    tbl[11] = '{1'b0, 8'd5,   {$urandom, $urandom}, -1, 0, 1'b0, 1,  -1, 1'b1};
    tbl[12] = '{1'b1, 8'd9,   {$urandom, $urandom},  2, 3, 1'b0, 2,  -1, 1'b0};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; cyclic = 1'b0; offset = '0;
    buckets = '0; key_ready_a = 1'b0; key_ready_b = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_a", 64'({key_valid_a, busy_a, done_a}), 64'd0);
    check("reset_a_data", 64'(key_data_a), 64'd0);
    check("reset_b", 64'({key_valid_b, busy_b, done_b}), 64'd0);
    check("reset_b_data", 64'(key_data_b), 64'd0);

    for (int i = 0; i < 13; i++) begin
      run_a(tbl[i]);
      if (i == 0) begin
        check("t1_beat0", 64'(got[0]), 64'h000304);
        check("t1_beat6", 64'(got[6]), 64'h060200);
        check("t1_beat7", 64'(got[7]), 64'h070600);
        got_t1 = got;
      end
      if (i == 1) begin
        check("t2_beat6", 64'(got[6]), 64'h060203);
        check("t2_beat7", 64'(got[7]), 64'h070601);
        for (int k = 0; k < 6; k++) check("t2_vs_t1", 64'(got[k]), 64'(got_t1[k]));
      end
      if (i == 2) got_t3 = got;
      if (i == 3) for (int k = 0; k < N; k++) check("off19_vs_off3", 64'(got_t3[k]), 64'(got[k]));
    end

    buckets = BK_T; cyclic = 1'b0; offset = 8'd1;
    start_b = 1'b1; key_ready_b = 1'b1;
    tick();
    start_b = 1'b0;
    buckets = '0;
    t = 0;
    while (!key_valid_b && t < 20) begin
      tick();
      t++;
    end
    check("b_latency", 64'(t), 64'd1);
    for (int b = 0; b < N/2; b++) begin
      expb = {mk(BK_T, 1'b0, 1, 2*b+1), mk(BK_T, 1'b0, 1, 2*b)};
      check("b_valid", 64'(key_valid_b), 64'd1);
      check($sformatf("b_beat%0d", b), 64'(key_data_b), 64'(expb));
      if (b == 3) check("b_beat3_const", 64'(key_data_b), 64'h070600_060206);
      tick();
    end
    check("b_done", 64'({done_b, key_valid_b}), 64'b10);
    tick();
    check("b_idle", 64'({done_b, busy_b}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
